frame_sync_checker: RTL and testbench

- Receiver back-end stage. Consumes the recovered serial bit stream from the receiver (receiver_data_o) and finds frame boundaries by sync-word correlation.
- Maintains lock through a hunt/confirm/lock/flywheel state machine.
- Checks the payload against a PRBS-7 reference and counts bit errors and good frames, so the bench can score link quality across channel interrupts.

---
 rtl/frame_sync_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_frame_sync_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_checker.sv
// frame_sync_checker: sync-word framer with hunt/confirm/lock/flywheel lock tracking and PRBS-7 payload scoring.
// Latency: every output is registered; the effect of a consumed bit is visible the cycle after its edge.
// Backpressure: none; bit_valid_i=0 freezes all state (frame_start_o drops to 0), err_clr_i acts on any cycle.
//
// Ports:
//   receiver_LO    clock, all logic on the rising edge
//   receiver_rst   synchronous active-high reset
//   bit_valid_i    qualifies data_i; only valid bits advance state
//   data_i         received serial bit (sync word MSB first)
//   err_clr_i      one-cycle pulse clearing both counters (wins over a same-cycle increment)
//   state_o        0=HUNT 1=CONFIRM 2=LOCK 3=FLYWHEEL
//   locked_o       high in LOCK or FLYWHEEL
//   frame_start_o  one-cycle pulse per accepted sync match
//   bit_err_cnt_o  saturating payload bit-error count
//   frame_cnt_o    saturating count of syncs accepted into LOCK/FLYWHEEL
//
// Build option: define FRAME_SYNC_PRBS_CHECK_EN to include the PRBS-7 (x^7+x^6+1)
// payload checker; without it bit_err_cnt_o is tied to 0 and payload bits are ignored.

module frame_sync_checker #(
  parameter int                  SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'hA5,
  parameter int                  FRAME_LEN  = 64,
  parameter int                  LOCK_CNT   = 3,
  parameter int                  UNLOCK_CNT = 2
) (
  input  logic        receiver_LO,
  input  logic        receiver_rst,
  input  logic        bit_valid_i,
  input  logic        data_i,
  input  logic        err_clr_i,
  output logic [1:0]  state_o,
  output logic        locked_o,
  output logic        frame_start_o,
  output logic [15:0] bit_err_cnt_o,
  output logic [15:0] frame_cnt_o
);

  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [1:0] ST_HUNT     = 2'd0;
  localparam logic [1:0] ST_CONFIRM  = 2'd1;
  localparam logic [1:0] ST_LOCK     = 2'd2;
  localparam logic [1:0] ST_FLYWHEEL = 2'd3;

  localparam logic [PW-1:0] POS_CHECK  = PW'(FRAME_LEN - 1);
  localparam logic [MW-1:0] LOCK_TGT   = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_TGT = UW'(UNLOCK_CNT);

  logic [SYNC_LEN-1:0] sr;
  logic [SYNC_LEN-1:0] sr_nxt;
  logic                match;
  logic                check_pos;
  logic [PW-1:0]       pos;
  logic [PW-1:0]       pos_nxt;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [MW-1:0]       match_cnt;
  logic [MW-1:0]       match_cnt_nxt;
  logic [MW-1:0]       match_inc;
  logic [UW-1:0]       miss_cnt;
  logic [UW-1:0]       miss_cnt_nxt;
  logic [UW-1:0]       miss_inc;
  logic                accept;
  logic                count_frame;

  // The sync window includes the bit being consumed, so a match is decided on
  // the same edge that shifts that bit in.
  assign sr_nxt    = {sr[SYNC_LEN-2:0], data_i};
  assign match     = (sr_nxt == SYNC_WORD);
  assign check_pos = (pos == POS_CHECK);
  assign match_inc = match_cnt + 1'b1;
  assign miss_inc  = miss_cnt + 1'b1;

  // Position restarts after an accepted sync; otherwise it free-runs modulo the
  // frame length, which is what keeps timing through FLYWHEEL misses.
  assign pos_nxt = (accept || check_pos) ? '0 : pos + 1'b1;

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    miss_cnt_nxt  = miss_cnt;
    accept        = 1'b0;
    count_frame   = 1'b0;
    case (state)
      ST_HUNT: begin
        // Free-running search: any bit position may start a frame.
        if (match) begin
          accept        = 1'b1;
          match_cnt_nxt = MW'(1);
          miss_cnt_nxt  = '0;
          if (LOCK_TGT <= MW'(1)) begin
            state_nxt   = ST_LOCK;
            count_frame = 1'b1;
          end else begin
            state_nxt   = ST_CONFIRM;
          end
        end
      end
      ST_CONFIRM: begin
        if (check_pos) begin
          if (match) begin
            accept        = 1'b1;
            match_cnt_nxt = match_inc;
            if (match_inc >= LOCK_TGT) begin
              state_nxt   = ST_LOCK;
              count_frame = 1'b1;
            end
          end else begin
            state_nxt     = ST_HUNT;
            match_cnt_nxt = '0;
          end
        end
      end
      ST_LOCK: begin
        if (check_pos) begin
          if (match) begin
            accept       = 1'b1;
            count_frame  = 1'b1;
            miss_cnt_nxt = '0;
          end else if (UNLOCK_TGT <= UW'(1)) begin
            state_nxt     = ST_HUNT;
            miss_cnt_nxt  = '0;
            match_cnt_nxt = '0;
          end else begin
            state_nxt    = ST_FLYWHEEL;
            miss_cnt_nxt = UW'(1);
          end
        end
      end
      default: begin // ST_FLYWHEEL
        if (check_pos) begin
          if (match) begin
            state_nxt    = ST_LOCK;
            accept       = 1'b1;
            count_frame  = 1'b1;
            miss_cnt_nxt = '0;
          end else if (miss_inc >= UNLOCK_TGT) begin
            state_nxt     = ST_HUNT;
            miss_cnt_nxt  = '0;
            match_cnt_nxt = '0;
          end else begin
            miss_cnt_nxt = miss_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge receiver_LO) begin
    if (receiver_rst) begin
      sr            <= '0;
      pos           <= '0;
      state         <= ST_HUNT;
      match_cnt     <= '0;
      miss_cnt      <= '0;
      locked_o      <= 1'b0;
      frame_start_o <= 1'b0;
      frame_cnt_o   <= 16'h0000;
    end else begin
      frame_start_o <= 1'b0;
      if (bit_valid_i) begin
        sr            <= sr_nxt;
        pos           <= pos_nxt;
        state         <= state_nxt;
        match_cnt     <= match_cnt_nxt;
        miss_cnt      <= miss_cnt_nxt;
        // LOCK and FLYWHEEL are the two codes with bit 1 set.
        locked_o      <= state_nxt[1];
        frame_start_o <= accept;
      end
      if (err_clr_i) begin
        frame_cnt_o <= 16'h0000;
      end else if (bit_valid_i && count_frame && (frame_cnt_o != 16'hFFFF)) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

  assign state_o = state;

`ifdef FRAME_SYNC_PRBS_CHECK_EN
  localparam logic [PW-1:0] PAYLOAD_LEN = PW'(FRAME_LEN - SYNC_LEN);
  localparam logic [6:0]    PRBS_SEED   = 7'h7F;

  logic [6:0] lfsr;
  logic       payload_bit;
  logic       prbs_bit;

  assign payload_bit = (pos < PAYLOAD_LEN);
  assign prbs_bit    = lfsr[6];

  // The generator steps on payload positions in every state so that it is
  // already aligned when lock is reached; only locked states score errors.
  always_ff @(posedge receiver_LO) begin
    if (receiver_rst) begin
      lfsr          <= PRBS_SEED;
      bit_err_cnt_o <= 16'h0000;
    end else begin
      if (bit_valid_i) begin
        if (accept) begin
          lfsr <= PRBS_SEED;
        end else if (payload_bit) begin
          lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
      end
      if (err_clr_i) begin
        bit_err_cnt_o <= 16'h0000;
      end else if (bit_valid_i && state[1] && payload_bit && (data_i != prbs_bit)
                   && (bit_err_cnt_o != 16'hFFFF)) begin
        bit_err_cnt_o <= bit_err_cnt_o + 16'd1;
      end
    end
  end
`else
  assign bit_err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_sync_checker.sv
// tb_frame_sync_checker: directed stimulus for frame_sync_checker with hand-computed expectations.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next one.
// Backpressure: bit_valid_i gapping is exercised by spacing valid bits with idle cycles.

module tb_frame_sync_checker;

  logic        receiver_LO = 1'b0;
  logic        receiver_rst;
  logic        bit_valid_i;
  logic        data_i;
  logic        err_clr_i;
  logic [1:0]  state_o;
  logic        locked_o;
  logic        frame_start_o;
  logic [15:0] bit_err_cnt_o;
  logic [15:0] frame_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int nbits    = 0;
  int n_pulse  = 0;
  int pulse_at [16];
  int gap      = 0;

  // PRBS-7 (x^7+x^6+1) from seed 7'h7F, first payload bit is the MSB.
  logic [55:0] payload = 56'b11111110000001000001100001010001111001000101100111010100;

`ifdef FRAME_SYNC_PRBS_CHECK_EN
  localparam int EXP_ERR_TWO = 2;
`else
  localparam int EXP_ERR_TWO = 0;
`endif

  frame_sync_checker dut (
    .receiver_LO   (receiver_LO),
    .receiver_rst  (receiver_rst),
    .bit_valid_i   (bit_valid_i),
    .data_i        (data_i),
    .err_clr_i     (err_clr_i),
    .state_o       (state_o),
    .locked_o      (locked_o),
    .frame_start_o (frame_start_o),
    .bit_err_cnt_o (bit_err_cnt_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 receiver_LO = ~receiver_LO;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    receiver_rst = 1'b1;
    bit_valid_i  = 1'b0;
    err_clr_i    = 1'b0;
    data_i       = 1'b0;
    repeat (n) begin
      @(posedge receiver_LO);
      #1;
    end
    receiver_rst = 1'b0;
    nbits   = 0;
    n_pulse = 0;
  endtask

  task automatic send_bit(input logic b, input logic clr);
    bit_valid_i = 1'b1;
    data_i      = b;
    err_clr_i   = clr;
    @(posedge receiver_LO);
    #1;
    bit_valid_i = 1'b0;
    err_clr_i   = 1'b0;
    nbits++;
    if (frame_start_o === 1'b1) begin
      if (n_pulse < 16) pulse_at[n_pulse] = nbits;
      n_pulse++;
    end
    for (int g = 0; g < gap; g++) begin
      data_i = ~b;
      @(posedge receiver_LO);
      #1;
    end
  endtask

  task automatic send_sync(input logic [7:0] sw);
    for (int i = 7; i >= 0; i--) send_bit(sw[i], 1'b0);
  endtask

  task automatic send_pay(input int lo, input int hi, input int f1, input int f2, input int clr_at);
    for (int k = lo; k <= hi; k++)
      send_bit(payload[55-k] ^ ((k == f1) || (k == f2)), (k == clr_at));
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic clean_run(input string p);
    do_reset(2);
    send_sync(8'hA5);
    chk({p, "_confirm_state"}, state_o, 1);
    chk({p, "_confirm_unlocked"}, locked_o, 0);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    chk({p, "_confirm2_state"}, state_o, 1);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    chk({p, "_lock_state"}, state_o, 2);
    chk({p, "_lock_locked"}, locked_o, 1);
    chk({p, "_lock_frame_cnt"}, frame_cnt_o, 1);
    chk({p, "_pulse_after_gap"}, frame_start_o, (gap == 0) ? 1 : 0);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    send_pay(0, 55, -1, -1, -1);
    chk({p, "_frame_cnt"}, frame_cnt_o, 3);
    chk({p, "_bit_err"}, bit_err_cnt_o, 0);
    chk({p, "_state_end"}, state_o, 2);
    chk({p, "_n_pulse"}, n_pulse, 5);
    for (int i = 0; i < 5; i++) chk({p, "_pulse_pos"}, pulse_at[i], 8 + 64 * i);
  endtask

  initial begin
    receiver_rst = 1'b0;
    bit_valid_i  = 1'b0;
    data_i       = 1'b0;
    err_clr_i    = 1'b0;

    // Reset then idle zeros.
    do_reset(3);
    chk("rst_state", state_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_frame_start", frame_start_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_bit_err", bit_err_cnt_o, 0);
    send_zeros(200);
    chk("idle_state", state_o, 0);
    chk("idle_locked", locked_o, 0);
    chk("idle_frame_cnt", frame_cnt_o, 0);
    chk("idle_bit_err", bit_err_cnt_o, 0);
    chk("idle_pulses", n_pulse, 0);

    // Clean framing, valid every cycle.
    gap = 0;
    clean_run("clean");

    // Injected payload errors while locked.
    send_sync(8'hA5);
    send_pay(0, 55, 10, 30, -1);
    chk("inj_bit_err", bit_err_cnt_o, EXP_ERR_TWO);
    chk("inj_state", state_o, 2);
    chk("inj_frame_cnt", frame_cnt_o, 4);
    send_sync(8'hA5);
    send_pay(0, 5, 5, -1, 5);
    chk("clr_bit_err", bit_err_cnt_o, 0);
    chk("clr_frame_cnt", frame_cnt_o, 0);
    send_pay(6, 55, -1, -1, -1);
    chk("clr_bit_err_hold", bit_err_cnt_o, 0);

    // Flywheel: one bad sync recovers, two consecutive drop lock.
    send_sync(8'hA4);
    chk("fly_state", state_o, 3);
    chk("fly_locked", locked_o, 1);
    chk("fly_no_pulse", frame_start_o, 0);
    chk("fly_frame_cnt", frame_cnt_o, 0);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    chk("fly_relock_state", state_o, 2);
    chk("fly_relock_pulse", frame_start_o, 1);
    chk("fly_relock_frame_cnt", frame_cnt_o, 1);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA4);
    chk("fly2_state", state_o, 3);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA4);
    chk("unlock_state", state_o, 0);
    chk("unlock_locked", locked_o, 0);
    chk("unlock_frame_cnt", frame_cnt_o, 1);

    // Channel interrupt: 150 zeros mid-lock, then clean frames.
    do_reset(1);
    chk("rst2_state", state_o, 0);
    for (int f = 0; f < 3; f++) begin
      send_sync(8'hA5);
      send_pay(0, 55, -1, -1, -1);
    end
    chk("ci_locked_before", state_o, 2);
    send_zeros(8);
    chk("ci_first_miss", state_o, 3);
    send_zeros(63);
    chk("ci_fly_hold", state_o, 3);
    send_zeros(1);
    chk("ci_hunt", state_o, 0);
    chk("ci_unlocked", locked_o, 0);
    send_zeros(78);
    chk("ci_hunt_end", state_o, 0);
    send_sync(8'hA5);
    chk("ci_confirm", state_o, 1);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    send_pay(0, 55, -1, -1, -1);
    send_sync(8'hA5);
    chk("ci_relock", locked_o, 1);
    chk("ci_relock_frame_cnt", frame_cnt_o, 2);

    // Gapped valid: one valid bit every third cycle.
    gap = 2;
    clean_run("gap");

    // Mid-frame reset at payload bit 20.
    send_sync(8'hA5);
    send_pay(0, 19, -1, -1, -1);
    chk("mid_frame_cnt_before", frame_cnt_o, 4);
    receiver_rst = 1'b1;
    bit_valid_i  = 1'b1;
    data_i       = payload[35];
    @(posedge receiver_LO);
    #1;
    receiver_rst = 1'b0;
    bit_valid_i  = 1'b0;
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_locked", locked_o, 0);
    chk("mid_rst_frame_cnt", frame_cnt_o, 0);
    chk("mid_rst_bit_err", bit_err_cnt_o, 0);
    chk("mid_rst_frame_start", frame_start_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
